// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write port of the instruction loader.
// The loader takes the slave modport; whatever feeds it bytes and watches the writes takes master.
interface instruction_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );
endinterface

// File: rtl/instruction_loader.sv
// Loads a framed program (A5, 16-bit count, N big-endian words, XOR checksum)
// into instruction memory, holding the CPU until a load completes cleanly.
//
// state  | meaning
// IDLE   | hunting for the A5 header, other bytes dropped
// CNT_HI | expecting word-count MSB
// CNT_LO | expecting word-count LSB, range check
// DATA   | assembling words, one memory write per 4 bytes
// CHECK  | expecting checksum byte
// FINISH | single dead cycle, input not accepted
module instruction_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input logic                 clk,
    input logic                 rst,
    instruction_loader_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA,
        CHECK,
        FINISH
    } state_t;

    localparam logic [31:0] MaxWords = 32'(MAX_WORDS);
    localparam logic [7:0]  Header   = 8'hA5;

    state_t      state;
    state_t      stateNext;

    logic [7:0]  cntHi;
    logic [15:0] wordsLeft;
    logic [1:0]  byteIdx;
    logic [31:0] assembler;
    logic [7:0]  checksum;
    logic [31:0] addrNext;

    logic        accept;
    logic [15:0] countFull;
    logic        countZero;
    logic        countTooBig;
    logic        wordDone;
    logic        lastWord;
    logic        checkOk;

    logic        startFrame;
    logic        loadCntHi;
    logic        loadCount;
    logic        shiftByte;
    logic        writeWord;
    logic        finishOk;
    logic        finishBad;

    assign bus.in_ready = (state != FINISH) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    assign countFull    = {cntHi, bus.in_data};
    assign countZero    = (countFull == 16'd0);
    assign countTooBig  = ({16'd0, countFull} > MaxWords);
    assign wordDone     = (byteIdx == 2'd3);
    assign lastWord     = (wordsLeft == 16'd1);
    assign checkOk      = (checksum == bus.in_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        startFrame = 1'b0;
        loadCntHi  = 1'b0;
        loadCount  = 1'b0;
        shiftByte  = 1'b0;
        writeWord  = 1'b0;
        finishOk   = 1'b0;
        finishBad  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && (bus.in_data == Header)) begin
                    stateNext  = CNT_HI;
                    startFrame = 1'b1;
                end
            end
            CNT_HI: begin
                if (accept) begin
                    stateNext = CNT_LO;
                    loadCntHi = 1'b1;
                end
            end
            CNT_LO: begin
                if (accept) begin
                    loadCount = 1'b1;
                    if (countTooBig) begin
                        stateNext = FINISH;
                        finishBad = 1'b1;
                    end else if (countZero) begin
                        stateNext = CHECK;
                    end else begin
                        stateNext = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    shiftByte = 1'b1;
                    if (wordDone) begin
                        writeWord = 1'b1;
                        if (lastWord) begin
                            stateNext = CHECK;
                        end
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    stateNext = FINISH;
                    finishOk  = checkOk;
                    finishBad = !checkOk;
                end
            end
            FINISH: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // All strobes are qualified by accept, so a stalled input freezes the datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            cntHi        <= 8'd0;
            wordsLeft    <= 16'd0;
            byteIdx      <= 2'd0;
            assembler    <= 32'd0;
            checksum     <= 8'd0;
            addrNext     <= BASE_ADDR;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= BASE_ADDR;
            bus.wr_data  <= 32'd0;
            bus.done     <= 1'b0;
            bus.error    <= 1'b0;
            bus.cpu_hold <= 1'b1;
        end else begin
            bus.wr_en <= writeWord;
            bus.done  <= finishOk;

            if (startFrame) begin
                bus.error    <= 1'b0;
                bus.cpu_hold <= 1'b1;
                byteIdx      <= 2'd0;
                addrNext     <= BASE_ADDR;
            end

            if (loadCntHi) begin
                cntHi    <= bus.in_data;
                checksum <= bus.in_data;
            end

            if (loadCount) begin
                wordsLeft <= countFull;
                checksum  <= checksum ^ bus.in_data;
            end

            if (shiftByte) begin
                assembler <= {assembler[23:0], bus.in_data};
                byteIdx   <= byteIdx + 2'd1;
                checksum  <= checksum ^ bus.in_data;
            end

            // Address wraps modulo 2^32 by plain 32-bit addition.
            if (writeWord) begin
                bus.wr_data <= {assembler[23:0], bus.in_data};
                bus.wr_addr <= addrNext;
                addrNext    <= addrNext + 32'd4;
                wordsLeft   <= wordsLeft - 16'd1;
            end

            if (finishOk) begin
                bus.cpu_hold <= 1'b0;
            end

            if (finishBad) begin
                bus.error <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instruction_loader.sv
// Directed frames into the loader; a negedge monitor checks every write against
// a scoreboard of hand-computed words and the cycle each word's last byte was taken.
module tb_instruction_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;

    instruction_loader_if bus();

    instruction_loader #(
        .BASE_ADDR(32'h0000_0000),
        .MAX_WORDS(256)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int doneCount = 0;
    logic prevDone = 1'b0;

    logic [63:0] expQ[$];
    int          dueQ[$];
    logic [7:0]  fr[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write, watches done pulses.
    always @(negedge clk) begin
        logic [63:0] e;
        int due;
        if (bus.wr_en === 1'b1) begin
            if (expQ.size() == 0) begin
                check("stray_wr_en", 32'(bus.wr_en), 32'd0);
            end else begin
                e = expQ.pop_front();
                check("wr_addr", bus.wr_addr, e[63:32]);
                check("wr_data", bus.wr_data, e[31:0]);
                due = (dueQ.size() != 0) ? dueQ.pop_front() : -1;
                check("wr_latency_cycle", 32'(cyc), 32'(due));
            end
        end
        if (bus.done === 1'b1) begin
            doneCount++;
            check("hold_low_with_done", 32'(bus.cpu_hold), 32'd0);
            check("done_one_cycle", 32'(prevDone), 32'd0);
        end
        prevDone = bus.done;
    end

    // Called in drive phase (just after a rising edge); returns in drive phase.
    task automatic sendByte(input logic [7:0] b, input int maxGap, input bit wordEnd);
        bit rdy;
        bit accepted;
        int gap;
        accepted = 1'b0;
        gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
        bus.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                accepted = 1'b1;
                break;
            end
        end
        check("byte_accepted", 32'(accepted), 32'd1);
        if (wordEnd) dueQ.push_back(cyc);
        bus.in_valid = 1'b0;
    endtask

    task automatic sendFrame(input int maxGap, input int nWrites);
        bit wordEnd;
        for (int i = 0; i < fr.size(); i++) begin
            wordEnd = (i >= 6) && (((i - 3) % 4) == 3) && (((i - 3) / 4) < nWrites);
            sendByte(fr[i], maxGap, wordEnd);
        end
    endtask

    task automatic runFrame(input string tag, input int maxGap, input int nWrites,
                            input logic expDone, input logic expErr, input logic expHold);
        int doneBefore;
        doneBefore = doneCount;
        sendFrame(maxGap, nWrites);
        @(negedge clk);
        check({tag, "_finish_in_ready"}, 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        #1;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_done_pulses"}, 32'(doneCount - doneBefore), 32'(expDone));
        check({tag, "_error"}, 32'(bus.error), 32'(expErr));
        check({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'(expHold));
        check({tag, "_writes_left"}, 32'(expQ.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_wr_en", 32'(bus.wr_en), 32'd0);
        check("reset_wr_addr", bus.wr_addr, 32'h0000_0000);
        check("reset_wr_data", bus.wr_data, 32'h0000_0000);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_error", 32'(bus.error), 32'd0);
        check("reset_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // single word, good checksum
        expQ.push_back({32'h0000_0000, 32'h2008_0005});
        fr = '{8'hA5, 8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
        runFrame("good1", 0, 1, 1'b1, 1'b0, 1'b0);

        // bad checksum: word still written, error sticky, hold stays
        expQ.push_back({32'h0000_0000, 32'h2008_0005});
        fr = '{8'hA5, 8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
        runFrame("badsum", 0, 1, 1'b0, 1'b1, 1'b1);

        // recovery frame restarts at base address
        expQ.push_back({32'h0000_0000, 32'h2008_0005});
        fr = '{8'hA5, 8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
        runFrame("recover", 0, 1, 1'b1, 1'b0, 1'b0);

        // N = 257 rejected
        fr = '{8'hA5, 8'h01, 8'h01};
        runFrame("toobig", 0, 0, 1'b0, 1'b1, 1'b1);

        // N = 0
        fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
        runFrame("zero", 0, 0, 1'b1, 1'b0, 1'b0);

        // 33 is dropped in IDLE and must not raise hold
        sendByte(8'h33, 0, 1'b0);
        @(negedge clk);
        check("junk_cpu_hold", 32'(bus.cpu_hold), 32'd0);
        @(posedge clk);
        #1;

        // three words with random in_valid gaps; checksum hand-computed as CF
        expQ.push_back({32'h0000_0000, 32'h1122_3344});
        expQ.push_back({32'h0000_0004, 32'h5566_7788});
        expQ.push_back({32'h0000_0008, 32'h99AA_BBCC});
        fr = '{8'hA5, 8'h00, 8'h03,
               8'h11, 8'h22, 8'h33, 8'h44,
               8'h55, 8'h66, 8'h77, 8'h88,
               8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hCF};
        runFrame("three", 3, 3, 1'b1, 1'b0, 1'b0);

        // reset after two data bytes
        sendByte(8'hA5, 0, 1'b0);
        sendByte(8'h00, 0, 1'b0);
        sendByte(8'h01, 0, 1'b0);
        sendByte(8'hAA, 0, 1'b0);
        sendByte(8'hBB, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check("midreset_wr_addr", bus.wr_addr, 32'h0000_0000);
        @(posedge clk);
        #1;
        sendByte(8'hCC, 0, 1'b0);
        sendByte(8'hDD, 0, 1'b0);

        // checksum 00^01^DE^AD^BE^EF = 23
        expQ.push_back({32'h0000_0000, 32'hDEAD_BEEF});
        fr = '{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
        runFrame("afterreset", 1, 1, 1'b1, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("final_expq_empty", 32'(expQ.size()), 32'd0);
        check("final_dueq_empty", 32'(dueQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, default 256, the largest accepted word count.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_data  input  8  incoming program byte.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid && in_ready at a rising edge.
REQ-008 wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 wr_addr  output  32  byte address of the word being written.
REQ-010 wr_data  output  32  instruction word being written.
REQ-011 cpu_hold  output  1  holds the pipeline (PC/buffers) while high.
REQ-012 done  output  1  one-cycle pulse on a successful load.
REQ-013 error  output  1  sticky flag for a failed load.

Function
REQ-014 Frame format SHALL be: header 8'hA5; count N, 16 bit, MSB byte first; N words of 4 bytes each, MSB byte first; checksum byte.
REQ-015 The checksum SHALL equal the XOR of all count and data bytes; the header and checksum bytes are excluded.
REQ-016 FSM states SHALL be IDLE, CNT_HI, CNT_LO, DATA, CHECK, FINISH.
REQ-017 In IDLE, an accepted byte of 8'hA5 SHALL:
- go to CNT_HI;
- clear error;
- raise cpu_hold.
Any other byte SHALL be accepted and discarded.
REQ-018 CNT_HI -> CNT_LO on byte accept. CNT_LO -> on byte accept:
- DATA if 1 <= N <= MAX_WORDS;
- CHECK if N = 0;
- FINISH with failure if N > MAX_WORDS.
REQ-019 In DATA:
- bytes SHALL shift into a 32-bit assembler;
- on the 4th byte of a word, the next cycle SHALL drive wr_en=1, wr_data=the assembled word, wr_addr=BASE_ADDR+4*k (k = word index from 0);
- latency is exactly 1 cycle from the accepting edge.
REQ-020 wr_addr arithmetic SHALL be 32-bit modulo 2^32, with no saturation.
REQ-021 After the N-th word's 4th byte is accepted, the FSM SHALL go to CHECK; the final wr_en still occurs per REQ-019.
REQ-022 In CHECK, on byte accept, the FSM SHALL go to FINISH.
- Match: done=1 for exactly one cycle, cpu_hold=0 in the same cycle and thereafter.
- Mismatch: error=1 (sticky), cpu_hold stays 1.
REQ-023 FINISH SHALL last one cycle with in_ready=0, then return to IDLE.
REQ-024 in_ready SHALL be 1 in all states except FINISH.
REQ-025 in_valid low SHALL stall the FSM indefinitely with no state, counter or checksum change.
REQ-026 wr_en SHALL be 0 in every cycle except those defined in REQ-019, and SHALL never assert for a frame rejected by REQ-018.
REQ-027 Words already written before a checksum mismatch SHALL remain written; there is no rollback, and error signals the failure.
REQ-028 A new header after an error SHALL restart the load from BASE_ADDR.

Reset
REQ-029 While rst=1 at an edge, the loader SHALL enter IDLE, discard any partial word, count and checksum, and drive:
- wr_en=0, wr_addr=BASE_ADDR, wr_data=0;
- done=0, error=0;
- cpu_hold=1;
- in_ready=0 during the reset cycle.
REQ-030 Reset mid-frame SHALL cause no further write; the frame restarts only on a new header.

Verification
REQ-031 Send A5 00 01 20 08 00 05 2C -> one wr_en with wr_addr=0, wr_data=32'h20080005; done pulse; cpu_hold falls; error=0.
REQ-032 Same frame with checksum 2D -> the word is written, error=1, cpu_hold=1, no done; a following valid frame clears error and loads correctly.
REQ-033 Send A5 01 01 (N=257 > 256) -> no wr_en ever, error=1 after the FINISH cycle.
REQ-034 Send A5 00 00 00 -> no wr_en, done pulse; bytes 33 A5 for the next frame, with 33 discarded in IDLE.
REQ-035 Send a 3-word frame with random in_valid gaps -> writes at 0, 4, 8 with correct data; each write exactly 1 cycle after its 4th byte.
REQ-036 Assert rst after 2 data bytes, then send a full valid frame -> no stray write; the new frame is written from BASE_ADDR.
